// File: rtl/alu_div_sequencer.sv
// Multi-cycle sequencer for the single-precision divider: time-shares one Newton-Raphson
// iteration stage and one multiplier. Optional build macro: ALU_DIV_EARLY_EXIT_EN.
module alu_div_sequencer #(
    parameter int          NUM_ITER   = 5,
    parameter logic [31:0] INIT_GUESS = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] it_x,
    output logic [31:0] it_d,
    input  logic [31:0] it_res,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exception
`ifdef ALU_DIV_EARLY_EXIT_EN
    ,
    output logic [3:0]  iters_used
`endif
);

    typedef enum logic [1:0] {IDLE, ITER, MUL, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state, next_state;
    logic [3:0]  count;
    logic        sign_reg;
    logic [31:0] div_reg;
    logic [31:0] opa_reg;
    logic [31:0] x_reg;
    logic        accept;
    logic        exc_in;
    logic        iter_last;

    assign accept = in_valid & in_ready;

    // Zero, denormal, Inf and NaN operands all bypass the iteration loop.
    assign exc_in = (&a_operand[30:23]) | (&b_operand[30:23]) |
                    (~|a_operand[30:23]) | (~|b_operand[30:23]);

`ifdef ALU_DIV_EARLY_EXIT_EN
    assign iter_last = (count == 4'(NUM_ITER - 1)) ||
                       ((count >= 4'd1) && (it_res == x_reg));
`else
    assign iter_last = (count == 4'(NUM_ITER - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = exc_in ? DONE : ITER;
            ITER:    if (iter_last) next_state = MUL;
            MUL:     next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        it_x      = '0;
        it_d      = '0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE: in_ready = ~reset;
            ITER: begin
                it_x = x_reg;
                it_d = div_reg;
            end
            MUL: begin
                mul_a = x_reg;
                mul_b = opa_reg;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Both multiplier operands are positive, so folding in mul_res[31] leaves sign_reg intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            sign_reg   <= 1'b0;
            div_reg    <= '0;
            opa_reg    <= '0;
            x_reg      <= '0;
            result     <= '0;
            exception  <= 1'b0;
`ifdef ALU_DIV_EARLY_EXIT_EN
            iters_used <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_reg  <= a_operand[31] ^ b_operand[31];
                        div_reg   <= {1'b0, 8'd126, b_operand[22:0]};
                        opa_reg   <= {1'b0, a_operand[30:23] + (8'd126 - b_operand[30:23]),
                                      a_operand[22:0]};
                        x_reg     <= INIT_GUESS;
                        count     <= '0;
                        exception <= exc_in;
`ifdef ALU_DIV_EARLY_EXIT_EN
                        iters_used <= '0;
`endif
                        if (exc_in) begin
                            result <= QNAN;
                        end
                    end
                end
                ITER: begin
                    x_reg <= it_res;
                    count <= count + 4'd1;
`ifdef ALU_DIV_EARLY_EXIT_EN
                    if (iter_last) begin
                        iters_used <= count + 4'd1;
                    end
`endif
                end
                MUL: begin
                    result <= {sign_reg ^ mul_res[31], mul_res[30:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with behavioural models of the iteration stage
// and the multiplier built from IEEE-754 single <-> real conversions.
module tb_alu_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] aOp = '0;
    logic [31:0] bOp = '0;
    logic [31:0] itX, itD, itRes;
    logic [31:0] mulA, mulB, mulRes;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;
    logic        exception;
`ifdef ALU_DIV_EARLY_EXIT_EN
    logic [3:0]  itersUsed;
`endif

    int checks = 0;
    int errors = 0;

    alu_div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a_operand (aOp),
        .b_operand (bOp),
        .it_x      (itX),
        .it_d      (itD),
        .it_res    (itRes),
        .mul_a     (mulA),
        .mul_b     (mulB),
        .mul_res   (mulRes),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (result),
        .exception (exception)
`ifdef ALU_DIV_EARLY_EXIT_EN
        ,
        .iters_used(itersUsed)
`endif
    );

    always #5 clk = ~clk;

    // Normal numbers only; a zero exponent field is treated as 0.0.
    function automatic real sglToReal(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    // Truncating conversion back to single precision.
    function automatic logic [31:0] realToSgl(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Reciprocal step x' = x * (2 - d*x) and a plain product, both same-cycle.
    assign itRes  = realToSgl(sglToReal(itX) * (2.0 - sglToReal(itD) * sglToReal(itX)));
    assign mulRes = realToSgl(sglToReal(mulA) * sglToReal(mulB));

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp, input int tol = 0);
        longint diff;
        checks++;
        diff = longint'(obs) - longint'(exp);
        if (diff < 0) diff = -diff;
        if ($isunknown(obs) || diff > longint'(tol)) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Presents operands and returns at the falling edge of cycle 1 after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aOp     = a;
        bOp     = b;
        inValid = 1'b1;
        checkOutput("in_ready_pre", 32'(inReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        aOp     = 32'hDEAD_BEEF;
        bOp     = 32'h1234_5678;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!outValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!outValid) checkOutput("timeout", 32'(outValid), 32'd1);
    endtask

    task automatic finishHandshake();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("ov_drop", 32'(outValid), 32'd0);
        checkOutput("ready_back", 32'(inReady), 32'd1);
    endtask

    task automatic runDivide(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expQ, input int tol);
        int lat;
        applyStimulus(a, b);
        waitValid(lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd7);
        checkOutput({tag, "_q"}, result, expQ, tol);
        checkOutput({tag, "_exc"}, 32'(exception), 32'd0);
        finishHandshake();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] prevX;
        logic [31:0] heldQ;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_exc", 32'(exception), 32'd0);
        checkOutput("rst_it_x", itX, 32'd0);
        checkOutput("rst_mul_b", mulB, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(inReady), 32'd1);

        // 6.0 / 2.0 with first-ITER operand checks
        applyStimulus(32'h40C0_0000, 32'h4000_0000);
        checkOutput("seq_it_x", itX, 32'h4000_0000);
        checkOutput("seq_it_d", itD, 32'h3F00_0000);
        checkOutput("seq_in_ready", 32'(inReady), 32'd0);
        checkOutput("seq_mul_b", mulB, 32'd0);
        waitValid(lat);
        checkOutput("div62_lat", 32'(lat), 32'd7);
        checkOutput("div62_q", result, 32'h4040_0000, 1);
        checkOutput("div62_exc", 32'(exception), 32'd0);
        finishHandshake();

        runDivide("sign", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1);

        // 1.0 / 3.0: the estimate moves on every iteration edge
        applyStimulus(32'h3F80_0000, 32'h4040_0000);
        checkOutput("tri_it_x1", itX, 32'h4000_0000);
        checkOutput("tri_it_d", itD, 32'h3F40_0000);
        prevX = itX;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tri_x_moved%0d", k), 32'(itX != prevX), 32'd1);
            if (k == 2) checkOutput("tri_x2", itX, 32'h3F80_0000);
            if (k == 3) checkOutput("tri_x3", itX, 32'h3FA0_0000);
            prevX = itX;
        end
        @(negedge clk);
        checkOutput("tri_mul_it_x", itX, 32'd0);
        checkOutput("tri_mul_b", mulB, 32'h3E80_0000);
        checkOutput("tri_mul_a", mulA, 32'h3FAA_AAAB, 1);
        @(negedge clk);
        checkOutput("tri_valid", 32'(outValid), 32'd1);
        checkOutput("tri_mul_b_idle", mulB, 32'd0);
        checkOutput("tri_q", result, 32'h3EAA_AAAB, 1);
        checkOutput("tri_exc", 32'(exception), 32'd0);
        finishHandshake();

        // Zero divisor short-circuits to a quiet NaN
        applyStimulus(32'h3F80_0000, 32'h0000_0000);
        checkOutput("zero_it_x", itX, 32'd0);
        waitValid(lat);
        checkOutput("zero_lat", 32'(lat), 32'd1);
        checkOutput("zero_q", result, 32'h7FC0_0000);
        checkOutput("zero_exc", 32'(exception), 32'd1);
        finishHandshake();

        // Backpressure: hold the result while new operands are offered
        applyStimulus(32'h40C0_0000, 32'h4000_0000);
        waitValid(lat);
        heldQ = result;
        checkOutput("bp_q", heldQ, 32'h4040_0000, 1);
        for (int i = 0; i < 10; i++) begin
            inValid = i[0];
            aOp     = $urandom;
            bOp     = $urandom;
            @(negedge clk);
            checkOutput($sformatf("bp_valid%0d", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("bp_hold%0d", i), result, heldQ);
            checkOutput($sformatf("bp_exc%0d", i), 32'(exception), 32'd0);
            checkOutput($sformatf("bp_ready%0d", i), 32'(inReady), 32'd0);
        end
        inValid = 1'b0;
        finishHandshake();
        @(negedge clk);
        checkOutput("bp_no_accept", 32'(itX), 32'd0);

        // Reset during the third ITER cycle abandons the operation
        applyStimulus(32'h40C0_0000, 32'h4000_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ov", 32'(outValid), 32'd0);
        checkOutput("mid_rst_ready", 32'(inReady), 32'd0);
        checkOutput("mid_rst_it_x", itX, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_idle", 32'(inReady), 32'd1);
        checkOutput("mid_rst_no_out", 32'(outValid), 32'd0);
        runDivide("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
